// File: rtl/fp_int_mac_pkg.sv
// Shared definitions for the fp_int_mul MAC tile: sequencer state encoding,
// default operand widths and FP16 field layout.
package fp_int_mac_pkg;

  localparam int ACT_WIDTH_DEF = 16;
  localparam int W_WIDTH_DEF   = 4;

  localparam int FP16_SIGN_W = 1;
  localparam int FP16_EXP_W  = 5;
  localparam int FP16_MAN_W  = 10;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FETCH = 3'd1,
    ST_ISSUE = 3'd2,
    ST_WAIT  = 3'd3,
    ST_DONE  = 3'd4
  } seq_state_t;

endpackage

// File: rtl/fp_int_mul_seq.sv
// Sequencer for one fp_int_mul datapath: streams cmd_len activation/weight pairs
// through the multiplier one at a time and frames the products for the accumulator.
module fp_int_mul_seq
  import fp_int_mac_pkg::*;
#(
  parameter int ACT_WIDTH = ACT_WIDTH_DEF,
  parameter int W_WIDTH   = W_WIDTH_DEF,
  parameter int LEN_W     = 8,
  parameter int TIMEOUT   = 64
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 cmd_start,
  input  logic [LEN_W-1:0]     cmd_len,
  input  logic                 cmd_abort,
  output logic                 busy,
  output logic                 done,
  output logic                 err,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [ACT_WIDTH-1:0] in_act,
  input  logic [W_WIDTH-1:0]   in_w,
  output logic                 mul_start,
  output logic [ACT_WIDTH-1:0] mul_act,
  output logic [W_WIDTH-1:0]   mul_w,
  input  logic                 mul_busy,
  input  logic                 mul_done,
  output logic                 acc_clear,
  output logic                 acc_valid,
  output logic                 acc_last
);

  localparam int TMR_W = $clog2(TIMEOUT + 1);

  seq_state_t       state;
  logic [LEN_W-1:0] len;
  logic [LEN_W-1:0] cnt;
  logic [TMR_W-1:0] timer;
  logic             last_pair;
  logic             timed_out;

  assign last_pair = (cnt == len - LEN_W'(1));
  assign timed_out = (timer == TMR_W'(TIMEOUT - 1));

  assign busy      = (state != ST_IDLE);
  assign in_ready  = (state == ST_FETCH);
  // An abort in the same cycle drops the in-flight product.
  assign acc_valid = (state == ST_WAIT) && mul_done && !cmd_abort;
  assign acc_last  = acc_valid && last_pair;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= ST_IDLE;
      len       <= '0;
      cnt       <= '0;
      timer     <= '0;
      err       <= 1'b0;
      done      <= 1'b0;
      mul_start <= 1'b0;
      acc_clear <= 1'b0;
      mul_act   <= '0;
      mul_w     <= '0;
    end else begin
      mul_start <= 1'b0;
      acc_clear <= 1'b0;
      done      <= 1'b0;
      if (cmd_abort) begin
        state <= ST_IDLE;
      end else begin
        case (state)
          ST_IDLE: begin
            if (cmd_start) begin
              err <= 1'b0;
              if (cmd_len != '0) begin
                len       <= cmd_len;
                cnt       <= '0;
                acc_clear <= 1'b1;
                state     <= ST_FETCH;
              end else begin
                done  <= 1'b1;
                state <= ST_DONE;
              end
            end
          end
          ST_FETCH: begin
            if (in_valid) begin
              mul_act <= in_act;
              mul_w   <= in_w;
              state   <= ST_ISSUE;
            end
          end
          ST_ISSUE: begin
            if (!mul_busy) begin
              mul_start <= 1'b1;
              timer     <= '0;
              state     <= ST_WAIT;
            end
          end
          ST_WAIT: begin
            // A result arriving on the timeout cycle still counts.
            if (mul_done) begin
              cnt <= cnt + LEN_W'(1);
              if (last_pair) begin
                done  <= 1'b1;
                state <= ST_DONE;
              end else begin
                state <= ST_FETCH;
              end
            end else if (timed_out) begin
              err   <= 1'b1;
              done  <= 1'b1;
              state <= ST_DONE;
            end else begin
              timer <= timer + TMR_W'(1);
            end
          end
          ST_DONE: begin
            state <= ST_IDLE;
          end
          default: begin
            state <= ST_IDLE;
          end
        endcase
      end
    end
  end

endmodule
